// File: rtl/mix_sequencer.sv
// Folds NVOICE enabled voice samples through one shared, multi-cycle mixer.
// Voices are combined in ascending index order; with no voices enabled the output is SILENCE.
module mix_sequencer #(
    parameter int          NVOICE  = 8,
    parameter int          MIX_LAT = 3,
    parameter logic [17:0] SILENCE = 18'h20000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NVOICE*18-1:0]   voices_in,
    input  logic [NVOICE-1:0]      voice_en,
    output logic [17:0]            mix_a,
    output logic [17:0]            mix_b,
    input  logic [17:0]            mix_z,
    output logic [17:0]            out_sample,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   overrun,
    input  logic                   clr_overrun
);
    localparam int IW = $clog2(NVOICE + 1);
    localparam int CW = $clog2(MIX_LAT + 1);

    typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_t;
    state_t state, next_state;

    logic [NVOICE*18-1:0] voices_l;
    logic [NVOICE-1:0]    en_l;
    logic [IW-1:0]        idx;
    logic [CW-1:0]        cnt;
    logic [17:0]          acc;
    logic                 acc_valid;
    logic [17:0]          cur_v;
    logic                 cur_en;
    logic                 accept, scan_end, load_first, issue, capture, advance;

    always_comb begin
        cur_v  = '0;
        cur_en = 1'b0;
        for (int i = 0; i < NVOICE; i++) begin
            if (idx == IW'(i)) begin
                cur_v  = voices_l[18*i +: 18];
                cur_en = en_l[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = SCAN;
            SCAN: begin
                if (idx == IW'(NVOICE))       next_state = DONE;
                else if (cur_en && acc_valid) next_state = WAIT;
            end
            WAIT: if (cnt == CW'(1)) next_state = SCAN;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        accept     = (state == IDLE) && start;
        scan_end   = (state == SCAN) && (idx == IW'(NVOICE));
        load_first = (state == SCAN) && !scan_end && cur_en && !acc_valid;
        issue      = (state == SCAN) && !scan_end && cur_en && acc_valid;
        capture    = (state == WAIT) && (cnt == CW'(1));
        advance    = ((state == SCAN) && !scan_end && !issue) || capture;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            voices_l   <= '0;
            en_l       <= '0;
            idx        <= '0;
            cnt        <= '0;
            acc        <= SILENCE;
            acc_valid  <= 1'b0;
            mix_a      <= SILENCE;
            mix_b      <= SILENCE;
            out_sample <= SILENCE;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            out_valid <= scan_end;
            // busy trails the state by one cycle so it spans SCAN/WAIT plus the DONE cycle
            busy      <= (state == SCAN) || (state == WAIT);
            if (accept) begin
                voices_l  <= voices_in;
                en_l      <= voice_en;
                idx       <= '0;
                acc_valid <= 1'b0;
            end
            if (load_first) begin
                acc       <= cur_v;
                acc_valid <= 1'b1;
            end
            if (issue) begin
                mix_a <= acc;
                mix_b <= cur_v;
                cnt   <= CW'(MIX_LAT);
            end else if (state == WAIT) begin
                cnt <= cnt - CW'(1);
            end
            if (capture)  acc <= mix_z;
            if (advance)  idx <= idx + IW'(1);
            if (scan_end) out_sample <= acc_valid ? acc : SILENCE;
        end
    end

    // a start that cannot be accepted (any non-IDLE state) is an overrun; set beats clear
    always_ff @(posedge clk) begin
        if (rst)                           overrun <= 1'b0;
        else if (start && state != IDLE)   overrun <= 1'b1;
        else if (clr_overrun)              overrun <= 1'b0;
    end
endmodule

// File: tb/tb_mix_sequencer.sv
// Directed bench for mix_sequencer with an adder model standing in for the shared mixer.
module tb_mix_sequencer;
    logic          clk = 1'b0;
    logic          rst, start, clr_overrun;
    logic [143:0]  voices_in;
    logic [7:0]    voice_en;
    logic [17:0]   mix_a, mix_b, mix_z, out_sample;
    logic          out_valid, busy, overrun;
    logic [17:0]   p0 = '0, p1 = '0;
    int            checks = 0, errors = 0;

    mix_sequencer #(.NVOICE(8), .MIX_LAT(3), .SILENCE(18'h20000)) dut (
        .clk(clk), .rst(rst), .start(start), .voices_in(voices_in), .voice_en(voice_en),
        .mix_a(mix_a), .mix_b(mix_b), .mix_z(mix_z), .out_sample(out_sample),
        .out_valid(out_valid), .busy(busy), .overrun(overrun), .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    // operands registered on edge N give a usable sum at the sampling edge N+3
    always @(posedge clk) begin
        p0 <= mix_a + mix_b;
        p1 <= p0;
    end
    assign mix_z = p1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one fold; optionally injects a second start ovr_at clocks after the start edge.
    task automatic fold(input string tag, input logic [7:0] en, input logic [143:0] v,
                        input logic [17:0] exp_s, input int exp_lat, input int exp_chg,
                        input int ovr_at);
        int lat, busyc, chg;
        logic got;
        logic [35:0] pab;
        voice_en = en; voices_in = v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        voice_en = 8'hFF;
        voices_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
        lat = 0; busyc = 0; chg = 0; got = 1'b0; pab = {mix_a, mix_b};
        while (!got && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            start = (lat == ovr_at);
            if (ovr_at > 0 && lat == ovr_at + 1) chk({tag, "_overrun"}, 32'(overrun), 32'd1);
            if (busy) busyc++;
            if ({mix_a, mix_b} != pab) chg++;
            pab = {mix_a, mix_b};
            if (out_valid) got = 1'b1;
        end
        start = 1'b0;
        chk({tag, "_seen"}, 32'(got), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_sample"}, 32'(out_sample), 32'(exp_s));
        chk({tag, "_busy_cycles"}, 32'(busyc), 32'(exp_lat));
        chk({tag, "_mix_changes"}, 32'(chg), 32'(exp_chg));
        @(posedge clk); #1;
        chk({tag, "_pulse_end"}, {30'd0, out_valid, busy}, 32'd0);
        chk({tag, "_hold"}, 32'(out_sample), 32'(exp_s));
    endtask

    initial begin
        logic [143:0] v;
        int nv;
        rst = 1'b1; start = 1'b0; clr_overrun = 1'b0; voices_in = '0; voice_en = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_flags", {29'd0, out_valid, busy, overrun}, 32'd0);
        chk("rst_mix_a", 32'(mix_a), 32'h20000);
        chk("rst_mix_b", 32'(mix_b), 32'h20000);
        chk("rst_out", 32'(out_sample), 32'h20000);

        for (int i = 0; i < 8; i++) v[18*i +: 18] = 18'(i + 1);
        fold("all8", 8'hFF, v, 18'd36, 30, 7, 0);
        fold("none", 8'h00, v, 18'h20000, 9, 0, 0);
        for (int i = 0; i < 8; i++) v[18*i +: 18] = 18'($urandom);
        v[2*18 +: 18] = 18'h01234;
        fold("single", 8'b0000_0100, v, 18'h01234, 9, 0, 0);

        for (int i = 0; i < 8; i++) v[18*i +: 18] = 18'(i + 1);
        fold("ovr", 8'hFF, v, 18'd36, 30, 7, 5);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        clr_overrun = 1'b1;
        @(posedge clk); #1 clr_overrun = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);

        // abort a fold with reset; also check set beats clear on the way in
        voice_en = 8'hFF; voices_in = v; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 start = 1'b1; clr_overrun = 1'b1;
        @(posedge clk); #1 start = 1'b0; clr_overrun = 1'b0;
        chk("set_wins", 32'(overrun), 32'd1);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        chk("abort_flags", {29'd0, out_valid, busy, overrun}, 32'd0);
        chk("abort_mix", {14'd0, mix_a ^ 18'h20000, mix_b == 18'h20000}, 32'd1);
        chk("abort_out", 32'(out_sample), 32'h20000);
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        nv = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid || busy) nv++;
        end
        chk("abort_no_valid", 32'(nv), 32'd0);

        // wrap-around: 0x3FFFF + 2 = 1 mod 2^18
        v = '0;
        v[0 +: 18]    = 18'h3FFFF;
        v[7*18 +: 18] = 18'h00002;
        fold("wrap", 8'b1000_0001, v, 18'h00001, 12, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
